regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single general write port and its PC write port between the two writeback sources of the pipeline: the ALU result and the memory load result. Each source uses a valid/ready handshake. A round-robin arbiter picks one source per cycle and presents the winner's write on registered outputs. A 16-entry pending-write scoreboard tracks reserved destination registers and flags read-after-write hazards to decode.

## Interface
Parameters:
- none (16 architectural registers, 32-bit data, R15 = PC; all fixed)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request granted this cycle (combinational)
- alu_dest  in  4  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request granted this cycle (combinational)
- mem_dest  in  4  load destination register
- mem_data  in  32  load data
- rsv_valid  in  1  decode reserves a destination this cycle
- rsv_dest  in  4  register being reserved
- read_1, read_2, read_3  in  1 each  decode will read src1/src2/src3
- src1_add, src2_add, src3_add  in  4 each  decode source addresses
- write  out  1  register-file write enable, general registers
- dest_add  out  4  register-file write address
- data_write  out  32  register-file write data
- write_pc  out  1  register-file PC write enable
- pc_next  out  32  new PC value
- busy  out  16  scoreboard; bit n set = write to Rn pending
- hazard  out  1  a source being read has its busy bit set (combinational)

## Operation
- Transfer: a source transfers in a cycle when its valid and ready are both 1. At most one transfer per cycle. Ready depends only on both valid inputs and the arbiter pointer, never on data or dest.
- Arbitration:
  - Only one valid: that source gets ready=1.
  - Both valid: the source not granted most recently gets ready=1.
  - Pointer `last` (1 bit: ALU/MEM) updates to the granted source on every transfer.
  - Reset value of `last` = MEM, so the ALU wins the first contention.
- A losing source holds valid, dest and data stable until it is granted. The arbiter never drops a request.
- Output register, loaded on the edge after a transfer:
  - Winner's dest ≠ 15: write=1, dest_add=dest, data_write=data, write_pc=0.
  - Winner's dest = 15: write_pc=1, pc_next=data, write=0. dest_add and data_write hold their previous values.
  - No transfer: write=0 and write_pc=0. Address and data registers hold.
- Scoreboard:
  - rsv_valid sets busy[rsv_dest] on the next edge.
  - An output-stage write (write=1, or write_pc=1 for R15) clears busy[dest] on the next edge. For R15 the cleared bit is busy[15].
  - Set and clear of the same bit in the same cycle: set wins, because it is a newer reservation.
  - A write to a non-busy register is legal and clears nothing.
- hazard = (read_1 & busy[src1_add]) | (read_2 & busy[src2_add]) | (read_3 & busy[src3_add]). It uses registered busy only; there is no bypass of same-cycle clears.

## Timing
- Latency from transfer edge to write/write_pc visible: 1 cycle. The register file captures the write on the following edge.
- Maximum throughput: one writeback per cycle. Under continuous contention the two sources alternate.
- busy bit set: visible 1 cycle after rsv_valid.
- busy bit clear: visible 1 cycle after the write/write_pc output pulse. hazard therefore deasserts 2 cycles after the transfer.
- Reset (reset_n=0 sampled at an edge):
  - write=0, write_pc=0, dest_add=0, data_write=0, pc_next=0, busy=16'h0000, last=MEM.
  - alu_ready=0 and mem_ready=0 while reset_n=0.
  - A transfer in the reset cycle is discarded. Reset mid-operation loses pending writes and clears all reservations.

## Test plan
- Single ALU write: alu_valid=1, alu_dest=5, alu_data=32'h76543219 → alu_ready=1 in the same cycle; next cycle write=1, dest_add=5, data_write=32'h76543219, write_pc=0.
- PC route: mem_valid=1, mem_dest=15, mem_data=32'h00000004 → next cycle write_pc=1, pc_next=32'h00000004, write=0.
- Contention: both valid for 4 cycles with ALU dest=1/data=1 and MEM dest=2/data=2 → grants alternate ALU, MEM, ALU, MEM, starting with ALU after reset; outputs follow with 1-cycle lag and nothing is lost.
- Scoreboard/hazard:
  - rsv_valid, rsv_dest=9 → busy=16'h0200 next cycle.
  - read_2=1, src2_add=9 → hazard=1.
  - ALU write to 9 → hazard clears 2 cycles after the transfer.
- Set/clear collision: output write to R3 in the same cycle as rsv_valid with rsv_dest=3 → busy[3] remains 1.
- Reset mid-operation: transfer accepted, then reset_n=0 on the next edge with busy=16'hFFFF → write=0, write_pc=0, busy=0, and the next contention is won by the ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Purpose: shares the register file's single general write port and its PC
// write port between the ALU writeback source and the memory-load writeback
// source. A round-robin arbiter grants one source per cycle; the winning
// write is presented one cycle later on registered outputs. A 16-entry
// scoreboard tracks reserved destination registers and flags read-after-write
// hazards to decode.
//
// Ports:
//   clock                    system clock, rising edge
//   reset_n                  synchronous active-low reset
//   alu_valid/ready/dest/data  ALU writeback handshake (ready is combinational)
//   mem_valid/ready/dest/data  load writeback handshake (ready is combinational)
//   rsv_valid, rsv_dest      decode reserves a destination register
//   read_1..3, src1..3_add   decode source reads for hazard detection
//   write, dest_add, data_write  registered general-register write port
//   write_pc, pc_next        registered PC (R15) write port
//   busy                     scoreboard, bit n set = write to Rn pending
//   hazard                   a source being read is busy (combinational)

module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_dest,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_dest,
  input  logic [31:0] mem_data,
  input  logic        rsv_valid,
  input  logic [3:0]  rsv_dest,
  input  logic        read_1,
  input  logic        read_2,
  input  logic        read_3,
  input  logic [3:0]  src1_add,
  input  logic [3:0]  src2_add,
  input  logic [3:0]  src3_add,
  output logic        write,
  output logic [3:0]  dest_add,
  output logic [31:0] data_write,
  output logic        write_pc,
  output logic [31:0] pc_next,
  output logic [15:0] busy,
  output logic        hazard
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  localparam logic [3:0] PC_REG = 4'd15;

  src_t        last;
  logic        transfer;
  logic [3:0]  win_dest;
  logic [31:0] win_data;
  logic [15:0] clear_mask;
  logic [15:0] set_mask;
  logic [15:0] busy_next;

  // Grants depend only on the two valids and the round-robin pointer. When
  // both request, the source that did not win most recently is granted.
  // Nothing is granted while reset is asserted, so a reset-cycle transfer
  // cannot happen.
  always_comb begin
    alu_ready = reset_n && alu_valid && (!mem_valid || (last == SRC_MEM));
    mem_ready = reset_n && mem_valid && (!alu_valid || (last == SRC_ALU));
  end

  // Winner selection; at most one ready is ever high.
  always_comb begin
    transfer = alu_ready || mem_ready;
    win_dest = alu_ready ? alu_dest : mem_dest;
    win_data = alu_ready ? alu_data : mem_data;
  end

  // Scoreboard next state. The write being presented this cycle retires its
  // reservation; a new reservation of the same register is newer and wins.
  always_comb begin
    clear_mask = ({16{write}} & (16'h0001 << dest_add))
               | {write_pc, 15'b0};
    set_mask   = {16{rsv_valid}} & (16'h0001 << rsv_dest);
    busy_next  = (busy & ~clear_mask) | set_mask;
  end

  // Hazard uses only the registered busy bits; no bypass of same-cycle clears.
  always_comb begin
    hazard = (read_1 && busy[src1_add])
          || (read_2 && busy[src2_add])
          || (read_3 && busy[src3_add]);
  end

  // Output stage, arbiter pointer and scoreboard. Write strobes are single
  // cycle pulses; address/data/PC registers hold until the next write that
  // targets them. R15 writes go to the PC port and leave the general port's
  // address and data untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write      <= 1'b0;
      write_pc   <= 1'b0;
      dest_add   <= 4'd0;
      data_write <= 32'd0;
      pc_next    <= 32'd0;
      busy       <= 16'h0000;
      last       <= SRC_MEM;
    end else begin
      write    <= 1'b0;
      write_pc <= 1'b0;
      busy     <= busy_next;
      if (transfer) begin
        last <= alu_ready ? SRC_ALU : SRC_MEM;
        if (win_dest == PC_REG) begin
          write_pc <= 1'b1;
          pc_next  <= win_data;
        end else begin
          write      <= 1'b1;
          dest_add   <= win_dest;
          data_write <= win_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Purpose: self-checking bench for regfile_wb_arbiter. Directed sequences
// cover reset, a single ALU write, the PC route, contention, the scoreboard
// and hazard path, the set/clear collision and reset mid-operation; a
// randomized phase follows. All outputs are compared every cycle against a
// behavioural model of the writeback port and reservation table.
//
// Ports: none (top-level bench).

module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_dest;
  logic [31:0] mem_data;
  logic        rsv_valid;
  logic [3:0]  rsv_dest;
  logic        read_1;
  logic        read_2;
  logic        read_3;
  logic [3:0]  src1_add;
  logic [3:0]  src2_add;
  logic [3:0]  src3_add;
  logic        write;
  logic [3:0]  dest_add;
  logic [31:0] data_write;
  logic        write_pc;
  logic [31:0] pc_next;
  logic [15:0] busy;
  logic        hazard;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model: which source won most recently, what the output port
  // shows, and the set of reserved registers.
  bit          mMemWasLast;
  bit          mWrite;
  bit          mWritePc;
  logic [3:0]  mDestAdd;
  logic [31:0] mDataWrite;
  logic [31:0] mPcNext;
  bit          mReserved [16];
  bit          mAluGrant;
  bit          mMemGrant;

  // Driver bookkeeping: a source that has not been granted must hold its
  // request unchanged.
  bit aluPending;
  bit memPending;

  regfile_wb_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_dest   (alu_dest),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .rsv_valid  (rsv_valid),
    .rsv_dest   (rsv_dest),
    .read_1     (read_1),
    .read_2     (read_2),
    .read_3     (read_3),
    .src1_add   (src1_add),
    .src2_add   (src2_add),
    .src3_add   (src3_add),
    .write      (write),
    .dest_add   (dest_add),
    .data_write (data_write),
    .write_pc   (write_pc),
    .pc_next    (pc_next),
    .busy       (busy),
    .hazard     (hazard)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mMemWasLast = 1'b1;
    mWrite      = 1'b0;
    mWritePc    = 1'b0;
    mDestAdd    = 4'd0;
    mDataWrite  = 32'd0;
    mPcNext     = 32'd0;
    foreach (mReserved[i]) mReserved[i] = 1'b0;
  endtask

  function automatic logic [15:0] modelBusy();
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = mReserved[i];
    return b;
  endfunction

  // One clock cycle: inputs are already driven; check at the falling edge,
  // then advance the model to what the next rising edge must produce.
  task automatic stepCycle();
    bit expHazard;
    @(negedge clock);
    if (reset_n) begin
      mAluGrant = alu_valid && (!mem_valid || mMemWasLast);
      mMemGrant = mem_valid && (!alu_valid || !mMemWasLast);
    end else begin
      mAluGrant = 1'b0;
      mMemGrant = 1'b0;
    end
    expHazard = (read_1 && mReserved[src1_add]) || (read_2 && mReserved[src2_add])
             || (read_3 && mReserved[src3_add]);
    checkOutput("alu_ready",  {31'b0, alu_ready}, {31'b0, mAluGrant});
    checkOutput("mem_ready",  {31'b0, mem_ready}, {31'b0, mMemGrant});
    checkOutput("write",      {31'b0, write},     {31'b0, mWrite});
    checkOutput("write_pc",   {31'b0, write_pc},  {31'b0, mWritePc});
    checkOutput("dest_add",   {28'b0, dest_add},  {28'b0, mDestAdd});
    checkOutput("data_write", data_write,         mDataWrite);
    checkOutput("pc_next",    pc_next,            mPcNext);
    checkOutput("busy",       {16'b0, busy},      {16'b0, modelBusy()});
    checkOutput("hazard",     {31'b0, hazard},    {31'b0, expHazard});

    if (!reset_n) begin
      modelReset();
    end else begin
      logic [3:0]  gDest;
      logic [31:0] gData;
      // Retire the write on the port now, then apply a newer reservation.
      if (mWrite)    mReserved[mDestAdd] = 1'b0;
      if (mWritePc)  mReserved[15] = 1'b0;
      if (rsv_valid) mReserved[rsv_dest] = 1'b1;
      mWrite   = 1'b0;
      mWritePc = 1'b0;
      if (mAluGrant || mMemGrant) begin
        gDest = mAluGrant ? alu_dest : mem_dest;
        gData = mAluGrant ? alu_data : mem_data;
        mMemWasLast = mMemGrant;
        if (gDest == 4'd15) begin
          mWritePc = 1'b1;
          mPcNext  = gData;
        end else begin
          mWrite     = 1'b1;
          mDestAdd   = gDest;
          mDataWrite = gData;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    alu_valid = 1'b0; alu_dest = 4'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_dest = 4'd0; mem_data = 32'd0;
    rsv_valid = 1'b0; rsv_dest = 4'd0;
    read_1 = 1'b0; read_2 = 1'b0; read_3 = 1'b0;
    src1_add = 4'd0; src2_add = 4'd0; src3_add = 4'd0;
  endtask

  task automatic applyReset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) stepCycle();
    reset_n = 1'b1;
  endtask

  // Random cycle: new requests only from sources that are not waiting.
  task automatic applyStimulus();
    if (!aluPending) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_dest  = 4'($urandom_range(0, 15));
      alu_data  = $urandom;
    end
    if (!memPending) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_dest  = 4'($urandom_range(0, 15));
      mem_data  = $urandom;
    end
    rsv_valid = ($urandom_range(0, 3) == 0);
    rsv_dest  = 4'($urandom_range(0, 15));
    read_1    = 1'($urandom_range(0, 1));
    read_2    = 1'($urandom_range(0, 1));
    read_3    = 1'($urandom_range(0, 1));
    src1_add  = 4'($urandom_range(0, 15));
    src2_add  = 4'($urandom_range(0, 15));
    src3_add  = 4'($urandom_range(0, 15));
    reset_n   = ($urandom_range(0, 60) != 0);
    stepCycle();
    aluPending = alu_valid && !mAluGrant;
    memPending = mem_valid && !mMemGrant;
  endtask

  initial begin
    idleInputs();
    modelReset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;

    // Reset with a request present: no grant may appear.
    alu_valid = 1'b1; alu_dest = 4'd4; alu_data = 32'hDEAD0004;
    applyReset(2);
    idleInputs();
    stepCycle();
    checkOutput("reset_busy", {16'b0, busy}, 32'h0);

    // Single ALU write to R5.
    alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 32'h76543219;
    stepCycle();
    idleInputs();
    stepCycle();

    // Load result routed to the PC.
    mem_valid = 1'b1; mem_dest = 4'd15; mem_data = 32'h00000004;
    stepCycle();
    idleInputs();
    stepCycle();

    // Contention after reset: ALU, MEM, ALU, MEM.
    applyReset(1);
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'd1;
    mem_valid = 1'b1; mem_dest = 4'd2; mem_data = 32'd2;
    repeat (4) stepCycle();
    idleInputs();
    stepCycle();

    // Reserve R9, read it, write it, and watch the hazard drop.
    rsv_valid = 1'b1; rsv_dest = 4'd9;
    stepCycle();
    idleInputs();
    checkOutput("busy_r9", {16'b0, busy}, 32'h0000_0200);
    read_2 = 1'b1; src2_add = 4'd9;
    stepCycle();
    alu_valid = 1'b1; alu_dest = 4'd9; alu_data = 32'h0000_0099;
    stepCycle();
    alu_valid = 1'b0;
    repeat (3) stepCycle();
    idleInputs();

    // Reservation of R3 in the same cycle the R3 write is on the port.
    rsv_valid = 1'b1; rsv_dest = 4'd3;
    stepCycle();
    idleInputs();
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 32'h0000_0333;
    stepCycle();
    idleInputs();
    rsv_valid = 1'b1; rsv_dest = 4'd3;
    stepCycle();
    idleInputs();
    stepCycle();
    checkOutput("busy_r3_kept", {31'b0, busy[3]}, 32'd1);

    // Reset mid-operation with every register reserved.
    for (int r = 0; r < 16; r++) begin
      rsv_valid = 1'b1; rsv_dest = 4'(r);
      stepCycle();
    end
    idleInputs();
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 32'h0000_0777;
    mem_valid = 1'b1; mem_dest = 4'd8; mem_data = 32'h0000_0888;
    stepCycle();
    idleInputs();
    checkOutput("busy_full", {16'b0, busy}, 32'h0000_FFFF);
    applyReset(1);
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'd1;
    mem_valid = 1'b1; mem_dest = 4'd2; mem_data = 32'd2;
    stepCycle();
    idleInputs();
    stepCycle();

    // Randomized traffic.
    aluPending = 1'b0;
    memPending = 1'b0;
    for (int n = 0; n < 600; n++) applyStimulus();
    reset_n = 1'b1;
    idleInputs();
    repeat (3) stepCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
